// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and instruction decode for the iterative MUL/DIV unit.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MFHI  = 3'd5,
        OP_MFLO  = 3'd6
    } op_t;

    // Only R-type instructions carry a meaningful function field.
    function automatic op_t decode_op(input logic [1:0] aluop, input logic [5:0] funct);
        op_t op;
        op = OP_NONE;
        if (aluop == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_MULT:  op = OP_MULT;
                FUNCT_MULTU: op = OP_MULTU;
                FUNCT_DIV:   op = OP_DIV;
                FUNCT_DIVU:  op = OP_DIVU;
                FUNCT_MFHI:  op = OP_MFHI;
                FUNCT_MFLO:  op = OP_MFLO;
                default:     op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Magnitude datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             last_c,
    output logic             is_div,
    output logic             neg_lo,
    output logic             neg_hi,
    output logic             div_zero,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        mag_a     = (op_signed && src_a[WIDTH-1]) ? (WIDTH'(0) - src_a) : src_a;
        mag_b     = (op_signed && src_b[WIDTH-1]) ? (WIDTH'(0) - src_b) : src_b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        last_c    = step && (cnt == CNT_W'(WIDTH-1));
    end

    // Bit WIDTH of div_diff is the borrow: set means the trial subtraction must be restored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd     <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (start) begin
            cnt      <= '0;
            is_div   <= op_div;
            neg_lo   <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_hi   <= op_signed && src_a[WIDTH-1];
            div_zero <= (src_b == '0);
            opnd     <= op_div ? mag_b : mag_a;
            acc_lo   <= op_div ? mag_a : mag_b;
            acc_hi   <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    acc_hi <= div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: decode, issue/flush FSM, pipeline stall and HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_t state;
    state_t state_next;
    op_t    op_c;

    logic is_muldiv_c;
    logic is_any_c;
    logic issue_c;
    logic start_c;
    logic step_c;
    logic write_c;
    logic op_div_c;
    logic op_signed_c;

    logic             last_c;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [2*WIDTH-1:0] prod_fix_c;
    logic [WIDTH-1:0]   res_hi_c;
    logic [WIDTH-1:0]   res_lo_c;

    always_comb begin
        op_c        = decode_op(ALUOp, Funct);
        is_muldiv_c = (op_c == OP_MULT) || (op_c == OP_MULTU) ||
                      (op_c == OP_DIV)  || (op_c == OP_DIVU);
        is_any_c    = (op_c != OP_NONE);
        op_div_c    = (op_c == OP_DIV)  || (op_c == OP_DIVU);
        op_signed_c = (op_c == OP_MULT) || (op_c == OP_DIV);
        issue_c     = Valid && !Flush && (state == ST_IDLE) && is_muldiv_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Flush wins over both issue and iteration.
    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (issue_c) state_next = op_div_c ? ST_DIV : ST_MUL;
                ST_MUL,
                ST_DIV:  if (last_c) state_next = ST_FIX;
                ST_FIX:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_c = 1'b0;
        step_c  = 1'b0;
        write_c = 1'b0;
        case (state)
            ST_IDLE: start_c = issue_c;
            ST_MUL,
            ST_DIV:  step_c  = !Flush;
            ST_FIX:  write_c = !Flush;
            default: ;
        endcase
    end

    assign Busy  = (state != ST_IDLE);
    assign Stall = !reset && Busy && Valid && is_any_c;

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .step     (step_c),
        .op_div   (op_div_c),
        .op_signed(op_signed_c),
        .src_a    (SrcA),
        .src_b    (SrcB),
        .last_c   (last_c),
        .is_div   (is_div),
        .neg_lo   (neg_lo),
        .neg_hi   (neg_hi),
        .div_zero (div_zero),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo)
    );

    // Sign correction; a zero divisor forces an all-ones quotient while the remainder is the dividend.
    always_comb begin
        prod_fix_c = neg_lo ? ((2*WIDTH)'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
        if (is_div) begin
            res_hi_c = neg_hi ? (WIDTH'(0) - acc_hi) : acc_hi;
            res_lo_c = div_zero ? '1 : (neg_lo ? (WIDTH'(0) - acc_lo) : acc_lo);
        end else begin
            res_hi_c = prod_fix_c[2*WIDTH-1:WIDTH];
            res_lo_c = prod_fix_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            Done <= write_c;
            if (write_c) begin
                HI <= res_hi_c;
                LO <= res_lo_c;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush, reset and stall sequences.
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Valid(valid),
        .ALUOp(aluop),
        .Funct(funct),
        .SrcA (src_a),
        .SrcB (src_b),
        .Flush(flush),
        .Busy (busy),
        .Stall(stall),
        .Done (done),
        .HI   (hi),
        .LO   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue at the coming edge, then watch 60 cycles; cycle n=1 is the one after the issue edge.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int done_idx, output int busy_cnt, output int done_cnt,
                         output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        valid = 1'b1; aluop = 2'b10; funct = f; src_a = a; src_b = b;
        @(negedge clk);
        valid = 1'b0; funct = 6'd0;
        done_idx = 0; busy_cnt = 0; done_cnt = 0; held = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            if (busy) busy_cnt++;
            if (busy && (hi !== h0 || lo !== l0)) held = 1'b0;
            if (done && done_idx == 0) done_idx = n;
            if (done) done_cnt++;
            if (n < 60) @(negedge clk);
        end
    endtask

    initial begin
        int  d_idx, b_cnt, d_cnt, stall_cnt;
        bit  held, done_seen;
        logic [31:0] h_prev, l_prev;

        vecs[0]  = '{"mult_neg2x3",   F_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{"divu_100_7",    F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2]  = '{"div_neg7_2",    F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_by_zero",  F_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[4]  = '{"div_min_neg1",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{"multu_max_sq",  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[6]  = '{"mult_7xneg5",   F_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vecs[7]  = '{"div_7_neg2",    F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{"multu_shift4",  F_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
        vecs[9]  = '{"div_neg_by_0",  F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[10] = '{"div_neg8_neg3", F_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};

        reset = 1'b1; valid = 1'b0; aluop = 2'b00; funct = 6'd0;
        src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b1; aluop = 2'b10; funct = F_MFLO;
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;

        // Non-R-type, unknown funct and flushed issue must all leave the unit idle.
        valid = 1'b1; aluop = 2'b00; funct = F_MULT;
        @(negedge clk);
        chk("non_rtype_ignored", 32'(busy), 32'd0);
        aluop = 2'b10; funct = 6'b100000;
        @(negedge clk);
        chk("unknown_funct_ignored", 32'(busy), 32'd0);
        funct = F_MULT; flush = 1'b1;
        @(negedge clk);
        chk("flush_beats_issue", 32'(busy), 32'd0);
        flush = 1'b0; valid = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, d_idx, b_cnt, d_cnt, held);
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            chk({vecs[i].name, "_latency"}, 32'(d_idx - 1), 32'd33);
            chk({vecs[i].name, "_busy_cycles"}, 32'(b_cnt), 32'd33);
            chk({vecs[i].name, "_done_pulses"}, 32'(d_cnt), 32'd1);
            chk({vecs[i].name, "_hold"}, 32'(held), 32'd1);
        end

        // MFHI while idle sees the current HI without stalling.
        valid = 1'b1; aluop = 2'b10; funct = F_MFHI;
        #1;
        chk("mfhi_idle_stall", 32'(stall), 32'd0);
        chk("mfhi_idle_value", hi, 32'hFFFF_FFFE);
        @(negedge clk);

        // MFLO one cycle behind a MULTU stalls until the result is written.
        funct = F_MULTU; src_a = 32'd3; src_b = 32'd5;
        #1;
        chk("issuer_not_stalled", 32'(stall), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1; funct = F_MFLO;
        stall_cnt = 0; done_seen = 1'b0;
        for (int n = 0; n < 40 && !done_seen; n++) begin
            #1;
            if (done) begin
                done_seen = 1'b1;
                chk("stall_in_done_cycle", 32'(stall), 32'd0);
                chk("mflo_new_lo", lo, 32'd15);
            end else begin
                if (stall) stall_cnt++;
                @(negedge clk);
            end
        end
        valid = 1'b0;
        chk("mflo_done_seen", 32'(done_seen), 32'd1);
        chk("mflo_stall_cycles", 32'(stall_cnt), 32'd32);
        @(negedge clk);

        // Flush during iteration 10 of a DIVU.
        h_prev = hi; l_prev = lo;
        valid = 1'b1; aluop = 2'b10; funct = F_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        d_cnt = 0;
        repeat (9) begin
            if (done) d_cnt++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) d_cnt++;
        chk("iter_flush_busy", 32'(busy), 32'd0);
        chk("iter_flush_hi", hi, h_prev);
        chk("iter_flush_lo", lo, l_prev);
        chk("iter_flush_no_done", 32'(d_cnt), 32'd0);
        do_op(F_MULTU, 32'd6, 32'd7, d_idx, b_cnt, d_cnt, held);
        chk("post_flush_lo", lo, 32'd42);
        chk("post_flush_hi", hi, 32'd0);
        chk("post_flush_latency", 32'(d_idx - 1), 32'd33);

        // Flush coinciding with the FIX edge suppresses the write.
        h_prev = hi; l_prev = lo;
        valid = 1'b1; aluop = 2'b10; funct = F_MULT; src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        valid = 1'b0;
        repeat (32) @(negedge clk);
        chk("fix_state_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fix_flush_done", 32'(done), 32'd0);
        chk("fix_flush_busy", 32'(busy), 32'd0);
        chk("fix_flush_lo", lo, l_prev);
        chk("fix_flush_hi", hi, h_prev);
        @(negedge clk);
        chk("fix_flush_done_late", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a MULT.
        valid = 1'b1; aluop = 2'b10; funct = F_MULT; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        valid = 1'b1; funct = F_MFLO;
        #1;
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        do_op(F_MULTU, 32'h0001_0000, 32'h0001_0001, d_idx, b_cnt, d_cnt, held);
        chk("post_reset_hi", hi, 32'd1);
        chk("post_reset_lo", lo, 32'h0001_0000);
        chk("post_reset_latency", 32'(d_idx - 1), 32'd33);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; WIDTH values other than 32 are outside scope.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Valid  input  1  EX-stage instruction valid this cycle.
REQ-005 SHALL have port ALUOp  input  2  main-control ALU op; 2'b10 = R-type.
REQ-006 SHALL have port Funct  input  6  R-type function field.
REQ-007 SHALL have port SrcA  input  WIDTH  rs operand (dividend / multiplicand).
REQ-008 SHALL have port SrcB  input  WIDTH  rt operand (divisor / multiplier).
REQ-009 SHALL have port Flush  input  1  pipeline flush; aborts any operation in progress.
REQ-010 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port Stall  output  1  freeze request to IF/ID/EX.
REQ-012 SHALL have port Done  output  1  one-cycle pulse when HI/LO are updated.
REQ-013 SHALL have port HI  output  WIDTH  HI register (product high half / remainder).
REQ-014 SHALL have port LO  output  WIDTH  LO register (product low half / quotient).

Function
REQ-015 SHALL decode Funct only when ALUOp==2'b10: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010; all other codes SHALL be ignored.
REQ-016 SHALL accept an operation ("issue") when Valid=1, Flush=0, state=IDLE and the decode is MULT/MULTU/DIV/DIVU; SrcA, SrcB and signedness SHALL be captured on that edge.
REQ-017 SHALL implement states IDLE -> MUL or DIV (issue) -> FIX (after WIDTH iterations) -> IDLE.
REQ-018 MUL SHALL perform one shift-add step per cycle on operand magnitudes, producing a 2*WIDTH unsigned product.
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle on operand magnitudes.
REQ-020 FIX SHALL apply sign correction for signed ops (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write HI/LO and pulse Done.
REQ-021 Latency SHALL be exactly WIDTH+1 cycles from the issue edge to the edge that updates HI/LO; Done SHALL be high in the cycle after that edge; Busy SHALL be high for exactly WIDTH+1 cycles.
REQ-022 HI/LO SHALL change only at FIX completion; intermediate iteration values SHALL NOT be visible on HI/LO.
REQ-023 Stall SHALL be combinational and high when Busy=1, Valid=1 and decode is any of the six codes in REQ-015; otherwise low.
REQ-024 MFHI/MFLO while IDLE SHALL see current HI/LO with no stall.
REQ-025 Divide by zero SHALL complete with normal latency, giving LO = all-ones and HI = SrcA as captured.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-027 Flush SHALL take priority over issue and over iteration: state -> IDLE on the next edge, HI/LO unchanged, no Done pulse.
REQ-028 Flush in the same cycle as a FIX-state edge SHALL suppress the HI/LO write.
REQ-029 The issuing instruction itself SHALL NOT be stalled; Stall asserts only for subsequent instructions.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE, Busy=0, Done=0, HI=0, LO=0, and clear iteration counter and working registers.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept a new issue on the first edge.
REQ-032 Stall SHALL be 0 while reset is asserted.

Structure
REQ-033 A shared package muldiv_pkg SHALL hold the Funct code constants, the state encoding (IDLE, MUL, DIV, FIX) and the default WIDTH.
REQ-034 The iteration datapath (magnitude registers, adder/subtractor, shift logic, counter) SHALL be a sub-module muldiv_iter_core; the FSM, decode, stall logic and HI/LO registers SHALL stay in muldiv_sequencer.

Verification
REQ-035 MULT SrcA=0xFFFFFFFE (-2), SrcB=3 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, one Done pulse, Busy high for 33 cycles.
REQ-036 DIVU SrcA=100, SrcB=7 -> LO=14, HI=2; signed DIV SrcA=-7, SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIVU SrcB=0, SrcA=0x1234 -> LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 MFLO presented 1 cycle after MULTU issue -> Stall high for 32 cycles, low in the Done cycle, and MFLO then reads the new LO.
REQ-039 Flush at iteration 10 of DIV -> Busy low next cycle, HI/LO keep prior values, no Done; a new MULTU issued next cycle completes correctly.
REQ-040 reset pulsed mid-MULT -> HI=LO=0, Busy=0 immediately (asynchronous); Stall=0 during reset.
